// File: rtl/output_port_allocator.sv
// Output-port allocator for a 5-port router: round-robin header arbitration, wormhole lock,
// downstream credit tracking and stall-timeout release.
module output_port_allocator #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Lreq,
    input  logic       Nreq,
    input  logic       Ereq,
    input  logic       Wreq,
    input  logic       Sreq,
    input  logic [2:0] Lflit_id,
    input  logic [2:0] Nflit_id,
    input  logic [2:0] Eflit_id,
    input  logic [2:0] Wflit_id,
    input  logic [2:0] Sflit_id,
    input  logic       credit_in,
    output logic [4:0] grant,
    output logic       fwd,
    output logic       busy,
    output logic       timeout_err,
    output logic [3:0] credits
);

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [3:0] DEPTH_C   = 4'(DEPTH);
    localparam logic [7:0] STALL_MAX = 8'(TIMEOUT - 1);
    localparam logic [2:0] HEADER    = 3'b001;
    localparam logic [2:0] TAIL      = 3'b100;

    state_t     state_q, state_d;
    logic [4:0] grant_q, grant_d;
    logic [2:0] rr_q, rr_d;
    logic [3:0] credits_q, credits_d;
    logic [7:0] stall_q, stall_d;
    logic       timeout_q, timeout_d;

    logic [4:0] req;
    logic [2:0] fid [5];
    logic [4:0] eligible;

    assign req    = {Sreq, Wreq, Ereq, Nreq, Lreq};
    assign fid[0] = Lflit_id;
    assign fid[1] = Nflit_id;
    assign fid[2] = Eflit_id;
    assign fid[3] = Wflit_id;
    assign fid[4] = Sflit_id;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_elig
            assign eligible[gi] = req[gi] && (fid[gi] == HEADER);
        end
    endgenerate

    // Round-robin search starting at rr_q, wrapping modulo 5.
    logic       win_found;
    logic [2:0] win_idx;
    logic [3:0] cand;
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 4'd0;
        for (int k = 0; k < 5; k++) begin
            cand = {1'b0, rr_q} + 4'(k);
            if (cand >= 4'd5) cand = cand - 4'd5;
            if (!win_found && eligible[cand[2:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[2:0];
            end
        end
    end

    // Decode the one-hot grant into the granted port's index, req and flit type.
    logic [2:0] g_idx;
    logic       g_req;
    logic [2:0] g_flit;
    always_comb begin
        g_idx  = 3'd0;
        g_req  = 1'b0;
        g_flit = 3'b000;
        for (int i = 0; i < 5; i++) begin
            if (grant_q[i]) begin
                g_idx  = 3'(i);
                g_req  = req[i];
                g_flit = fid[i];
            end
        end
    end

    logic [2:0] rr_after;
    assign rr_after = (g_idx == 3'd4) ? 3'd0 : g_idx + 3'd1;

    assign fwd         = (state_q == LOCKED) && g_req && (credits_q != 4'd0);
    assign busy        = (state_q == LOCKED);
    assign grant       = grant_q;
    assign credits     = credits_q;
    assign timeout_err = timeout_q;

    always_comb begin
        credits_d = credits_q;
        case ({fwd, credit_in})
            2'b10:   credits_d = credits_q - 4'd1;
            2'b01:   credits_d = (credits_q == DEPTH_C) ? credits_q : credits_q + 4'd1;
            default: credits_d = credits_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        stall_d   = stall_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = LOCKED;
                    grant_d = 5'b00001 << win_idx;
                    stall_d = 8'd0;
                end
            end
            LOCKED: begin
                if (fwd) begin
                    stall_d = 8'd0;
                    if (g_flit == TAIL) begin
                        state_d = IDLE;
                        grant_d = 5'b00000;
                        rr_d    = rr_after;
                    end
                end else if (stall_q == STALL_MAX) begin
                    state_d   = IDLE;
                    grant_d   = 5'b00000;
                    rr_d      = rr_after;
                    timeout_d = 1'b1;
                end else begin
                    stall_d = stall_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 5'b00000;
            rr_q      <= 3'd0;
            credits_q <= DEPTH_C;
            stall_q   <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            credits_q <= credits_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

endmodule
